// File: rtl/id_ex_register.sv
// ----------------------------------------------------------------------------
// id_ex_register
// Decode -> execute pipeline register for the MIPS datapath.
//  - Captures operands, register addresses, immediate and control bits.
//  - Bypasses a same-cycle write-back into the captured operands (r0 excluded).
//  - Detects load-use hazards, inserts one bubble and requests an upstream hold.
//  - Supports flush (branch/jump taken) and an external debug halt.
// Optional build macro: ID_EX_BUBBLE_COUNT_EN adds o_bubble_count, a 16-bit
// saturating count of edges on which a flush or hazard bubble was inserted.
// ----------------------------------------------------------------------------
module id_ex_register #(
   parameter int NB_DATA = 32,
   parameter int NB_REG  = 5
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_valid,
   input  logic               i_flush,
   input  logic               i_halt,
   input  logic [NB_REG-1:0]  i_addr_ra,
   input  logic [NB_REG-1:0]  i_addr_rb,
   input  logic [NB_REG-1:0]  i_addr_rd,
   input  logic [NB_DATA-1:0] i_data_ra,
   input  logic [NB_DATA-1:0] i_data_rb,
   input  logic [NB_DATA-1:0] i_imm,
   input  logic               i_mem_read,
   input  logic               i_reg_write,
   input  logic               i_wb_rw,
   input  logic [NB_REG-1:0]  i_wb_addr,
   input  logic [NB_DATA-1:0] i_wb_data,
   output logic               o_valid,
   output logic [NB_DATA-1:0] o_data_ra,
   output logic [NB_DATA-1:0] o_data_rb,
   output logic [NB_REG-1:0]  o_addr_ra,
   output logic [NB_REG-1:0]  o_addr_rb,
   output logic [NB_REG-1:0]  o_addr_rd,
   output logic [NB_DATA-1:0] o_imm,
   output logic               o_mem_read,
   output logic               o_reg_write,
   output logic               o_stall
`ifdef ID_EX_BUBBLE_COUNT_EN
   ,
   output logic [15:0]        o_bubble_count
`endif
);

   logic               hz;
   logic               rd_hits_ra;
   logic               rd_hits_rb;
   logic               bubble;
   logic [NB_DATA-1:0] operand_ra;
   logic [NB_DATA-1:0] operand_rb;

   // Operand select for one read port: r0 reads zero, a same-cycle write-back
   // to a non-zero address wins over the bank's (stale) read data.
   function automatic logic [NB_DATA-1:0] select_operand(
      input logic [NB_REG-1:0]  addr,
      input logic [NB_DATA-1:0] bank_data,
      input logic               wb_rw,
      input logic [NB_REG-1:0]  wb_addr,
      input logic [NB_DATA-1:0] wb_data
   );
      logic [NB_DATA-1:0] result;
      if (addr == '0)
         result = '0;
      else if (wb_rw && (wb_addr == addr))
         result = wb_data;
      else
         result = bank_data;
      return result;
   endfunction

   // Load-use hazard detection and upstream hold request.
   always_comb begin
      rd_hits_ra = (o_addr_rd == i_addr_ra);
      rd_hits_rb = (o_addr_rd == i_addr_rb);
      hz         = i_valid && o_valid && o_mem_read && (o_addr_rd != '0)
                   && (rd_hits_ra || rd_hits_rb);
      o_stall    = hz && !i_flush;
      bubble     = i_flush || hz;
   end

   // Bypass-aware operand selection for both read ports.
   always_comb begin
      operand_ra = select_operand(i_addr_ra, i_data_ra, i_wb_rw, i_wb_addr, i_wb_data);
      operand_rb = select_operand(i_addr_rb, i_data_rb, i_wb_rw, i_wb_addr, i_wb_data);
   end

   // Pipeline register: halt holds, flush/hazard inserts a bubble, else load.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         o_valid     <= 1'b0;
         o_data_ra   <= '0;
         o_data_rb   <= '0;
         o_addr_ra   <= '0;
         o_addr_rb   <= '0;
         o_addr_rd   <= '0;
         o_imm       <= '0;
         o_mem_read  <= 1'b0;
         o_reg_write <= 1'b0;
      end else if (i_halt) begin
         o_valid     <= o_valid;
         o_data_ra   <= o_data_ra;
         o_data_rb   <= o_data_rb;
         o_addr_ra   <= o_addr_ra;
         o_addr_rb   <= o_addr_rb;
         o_addr_rd   <= o_addr_rd;
         o_imm       <= o_imm;
         o_mem_read  <= o_mem_read;
         o_reg_write <= o_reg_write;
      end else if (bubble) begin
         o_valid     <= 1'b0;
         o_data_ra   <= '0;
         o_data_rb   <= '0;
         o_addr_ra   <= '0;
         o_addr_rb   <= '0;
         o_addr_rd   <= '0;
         o_imm       <= '0;
         o_mem_read  <= 1'b0;
         o_reg_write <= 1'b0;
      end else begin
         o_valid     <= i_valid;
         o_data_ra   <= operand_ra;
         o_data_rb   <= operand_rb;
         o_addr_ra   <= i_addr_ra;
         o_addr_rb   <= i_addr_rb;
         o_addr_rd   <= i_addr_rd;
         o_imm       <= i_imm;
         o_mem_read  <= i_valid && i_mem_read;
         o_reg_write <= i_valid && i_reg_write;
      end
   end

`ifdef ID_EX_BUBBLE_COUNT_EN
   // Saturating count of inserted bubbles; halted edges are not counted.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset)
         o_bubble_count <= '0;
      else if (!i_halt && bubble && (o_bubble_count != '1))
         o_bubble_count <= o_bubble_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// ----------------------------------------------------------------------------
// tb_id_ex_register
// Directed scenarios followed by randomized traffic, all checked against a
// cycle-level behavioural model of the decode/execute register.
// Define ID_EX_BUBBLE_COUNT_EN to also check o_bubble_count.
// ----------------------------------------------------------------------------
module tb_id_ex_register;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, flush, halt;
   logic [4:0]  addr_ra, addr_rb, addr_rd, wb_addr;
   logic [31:0] data_ra, data_rb, imm, wb_data;
   logic        mem_read, reg_write, wb_rw;

   logic        o_valid, o_mem_read, o_reg_write, o_stall;
   logic [31:0] o_data_ra, o_data_rb, o_imm;
   logic [4:0]  o_addr_ra, o_addr_rb, o_addr_rd;
`ifdef ID_EX_BUBBLE_COUNT_EN
   logic [15:0] o_bubble_count;
`endif

   int unsigned errors = 0;
   int unsigned checks = 0;

   typedef struct packed {
      logic        v;
      logic [31:0] a, b;
      logic [4:0]  xa, xb, xd;
      logic [31:0] imm;
      logic        mr, rw;
   } ex_t;

   ex_t         m;
   int unsigned bub;

   id_ex_register #(.NB_DATA(32), .NB_REG(5)) dut (
      .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .i_flush(flush),
      .i_halt(halt), .i_addr_ra(addr_ra), .i_addr_rb(addr_rb),
      .i_addr_rd(addr_rd), .i_data_ra(data_ra), .i_data_rb(data_rb),
      .i_imm(imm), .i_mem_read(mem_read), .i_reg_write(reg_write),
      .i_wb_rw(wb_rw), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
      .o_valid(o_valid), .o_data_ra(o_data_ra), .o_data_rb(o_data_rb),
      .o_addr_ra(o_addr_ra), .o_addr_rb(o_addr_rb), .o_addr_rd(o_addr_rd),
      .o_imm(o_imm), .o_mem_read(o_mem_read), .o_reg_write(o_reg_write),
      .o_stall(o_stall)
`ifdef ID_EX_BUBBLE_COUNT_EN
      , .o_bubble_count(o_bubble_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // What the register file port delivers once write-back bypass is applied.
   function automatic logic [31:0] read_value(input logic [4:0] ad, input logic [31:0] bank);
      if (ad == 5'd0) return 32'd0;
      if (wb_rw && wb_addr == ad) return wb_data;
      return bank;
   endfunction

   function automatic logic model_hz();
      return valid && m.v && m.mr && (m.xd != 5'd0) && (m.xd == addr_ra || m.xd == addr_rb);
   endfunction

   task automatic check_all();
      chk("valid",     {31'd0, o_valid},     {31'd0, m.v});
      chk("data_ra",   o_data_ra,            m.a);
      chk("data_rb",   o_data_rb,            m.b);
      chk("addr_ra",   {27'd0, o_addr_ra},   {27'd0, m.xa});
      chk("addr_rb",   {27'd0, o_addr_rb},   {27'd0, m.xb});
      chk("addr_rd",   {27'd0, o_addr_rd},   {27'd0, m.xd});
      chk("imm",       o_imm,                m.imm);
      chk("mem_read",  {31'd0, o_mem_read},  {31'd0, m.mr});
      chk("reg_write", {31'd0, o_reg_write}, {31'd0, m.rw});
`ifdef ID_EX_BUBBLE_COUNT_EN
      chk("bubbles",   {16'd0, o_bubble_count}, bub);
`endif
   endtask

   // Inputs are already driven; check the hold request, clock once, check state.
   task automatic tick();
      ex_t  n;
      logic hz;
      #1;
      hz = model_hz();
      chk("stall", {31'd0, o_stall}, {31'd0, hz && !flush});
      if (halt) begin
         n = m;
      end else if (flush || hz) begin
         n = '0;
         if (bub < 32'hFFFF) bub++;
      end else begin
         n.v   = valid;
         n.a   = read_value(addr_ra, data_ra);
         n.b   = read_value(addr_rb, data_rb);
         n.xa  = addr_ra;
         n.xb  = addr_rb;
         n.xd  = addr_rd;
         n.imm = imm;
         n.mr  = valid && mem_read;
         n.rw  = valid && reg_write;
      end
      @(posedge clk);
      #1;
      m = n;
      check_all();
   endtask

   task automatic idle_inputs();
      valid = 0; flush = 0; halt = 0; addr_ra = 0; addr_rb = 0; addr_rd = 0;
      data_ra = 0; data_rb = 0; imm = 0; mem_read = 0; reg_write = 0;
      wb_rw = 0; wb_addr = 0; wb_data = 0;
   endtask

   initial begin
      idle_inputs();
      m   = '0;
      bub = 0;
      rst_n = 1'b0;
      #3;
      check_all();
      chk("stall_rst", {31'd0, o_stall}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Normal load after reset
      valid = 1; addr_ra = 5'b10101; data_ra = 15; addr_rb = 5'b10111; data_rb = 20;
      imm = 7; addr_rd = 5'd9; reg_write = 1;
      tick();
      chk("load_ra", o_data_ra, 32'd15);
      chk("load_rb", o_data_rb, 32'd20);
      chk("load_imm", o_imm, 32'd7);

      // Write-back bypass, then r0 never bypassed
      wb_rw = 1; wb_addr = 5'b10111; wb_data = 88;
      tick();
      chk("bypass_rb", o_data_rb, 32'd88);
      addr_ra = 0; wb_addr = 0;
      tick();
      chk("r0_ra", o_data_ra, 32'd0);
      wb_rw = 0;

      // Load-use: one bubble, dependent captured next edge
      addr_ra = 1; addr_rb = 2; addr_rd = 3; mem_read = 1; reg_write = 1; data_ra = 11;
      tick();
      addr_ra = 3; addr_rb = 4; addr_rd = 5; mem_read = 0; data_ra = 33;
      tick();
      chk("lu_bubble", {31'd0, o_valid}, 32'd0);
      tick();
      chk("lu_dep_valid", {31'd0, o_valid}, 32'd1);
      chk("lu_dep_ra", {27'd0, o_addr_ra}, 32'd3);

      // Flush wins over hazard: no hold, bubble
      addr_ra = 1; addr_rd = 6; mem_read = 1;
      tick();
      addr_ra = 6; mem_read = 0; flush = 1;
      tick();
      chk("flush_rw", {31'd0, o_reg_write}, 32'd0);
      flush = 0;

      // Halt with changing inputs, then halt+flush
      addr_ra = 7; addr_rb = 8; addr_rd = 9; data_ra = 70; data_rb = 80; imm = 90;
      tick();
      halt = 1;
      for (int i = 0; i < 3; i++) begin
         addr_ra = 5'(i + 10); data_ra = 32'(i * 3 + 100); imm = 32'(i);
         tick();
      end
      flush = 1;
      tick();
      chk("halt_ra", o_data_ra, 32'd70);
      halt = 0; flush = 0;

      // Asynchronous reset in the middle of a stall
      addr_ra = 2; addr_rd = 12; mem_read = 1;
      tick();
      addr_ra = 12; mem_read = 0;
      #1;
      chk("pre_rst_stall", {31'd0, o_stall}, 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      m   = '0;
      bub = 0;
      check_all();
      chk("rst_stall", {31'd0, o_stall}, 32'd0);
      #2;
      rst_n = 1'b1;

      // Randomized traffic over a small register range to provoke hazards
      for (int i = 0; i < 400; i++) begin
         valid     = ($urandom_range(9) != 0);
         flush     = ($urandom_range(11) == 0);
         halt      = ($urandom_range(9) == 0);
         addr_ra   = 5'($urandom_range(4));
         addr_rb   = 5'($urandom_range(4));
         addr_rd   = 5'($urandom_range(4));
         data_ra   = $urandom;
         data_rb   = $urandom;
         imm       = $urandom;
         mem_read  = ($urandom_range(2) == 0);
         reg_write = $urandom_range(1);
         wb_rw     = $urandom_range(1);
         wb_addr   = 5'($urandom_range(4));
         wb_data   = $urandom;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
